alu_pipe_cc: RTL and testbench



---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_pipe_cc_if.sv | 53 +++++
 rtl/alu_core.sv | 70 +++++++
 rtl/alu_pipe_cc.sv | 134 +++++++++++++
 tb/tb_alu_pipe_cc.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the pipelined Y86-64 ALU (alu_pipe_cc).
//   FN_*      : Y86 OPq function codes (ifun field values)
//   cc_t      : architectural condition-code register layout
//   CC_RESET  : condition codes after reset (Y86 initial CC: ZF=1)
// Optional macro ALU_PIPE_CARRY_FLAG_EN adds a carry flag (cf) to cc_t.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int FN_ADD = 0;
    localparam int FN_SUB = 1;
    localparam int FN_AND = 2;
    localparam int FN_XOR = 3;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
`ifdef ALU_PIPE_CARRY_FLAG_EN
        logic cf;
`endif
    } cc_t;

`ifdef ALU_PIPE_CARRY_FLAG_EN
    localparam cc_t CC_RESET = '{1'b1, 1'b0, 1'b0, 1'b0};
`else
    localparam cc_t CC_RESET = '{1'b1, 1'b0, 1'b0};
`endif

endpackage

// File: rtl/alu_pipe_cc_if.sv
// ---------------------------------------------------------------------------
// alu_pipe_cc_if
// Handshake/bus bundle between decode/operand-fetch, the ALU and writeback.
//   in_valid/in_ready   : operand beat handshake
//   in_a/in_b           : signed operands, in_fn: OPq code, in_set_cc
//   out_valid/out_ready : result beat handshake
//   out_result/out_ovf/out_err : result, signed overflow, illegal fn
//   cc_zf/cc_sf/cc_of   : committed condition codes
// Optional macro ALU_PIPE_CARRY_FLAG_EN adds out_cf and cc_cf.
// Modports: slave = ALU side, master = surrounding datapath side.
// ---------------------------------------------------------------------------
interface alu_pipe_cc_if #(
    parameter int WIDTH = 64,
    parameter int FN_W  = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [FN_W-1:0]  in_fn;
    logic             in_set_cc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_ovf;
    logic             out_err;
    logic             cc_zf;
    logic             cc_sf;
    logic             cc_of;
`ifdef ALU_PIPE_CARRY_FLAG_EN
    logic             out_cf;
    logic             cc_cf;
`endif

    modport slave (
        input  in_valid, in_a, in_b, in_fn, in_set_cc, out_ready,
        output in_ready, out_valid, out_result, out_ovf, out_err,
        output cc_zf, cc_sf, cc_of
`ifdef ALU_PIPE_CARRY_FLAG_EN
        , output out_cf, cc_cf
`endif
    );

    modport master (
        output in_valid, in_a, in_b, in_fn, in_set_cc, out_ready,
        input  in_ready, out_valid, out_result, out_ovf, out_err,
        input  cc_zf, cc_sf, cc_of
`ifdef ALU_PIPE_CARRY_FLAG_EN
        , input out_cf, cc_cf
`endif
    );

endinterface

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
// Combinational OPq execute unit: (a, b, fn) -> (result, ovf, err[, cf]).
//   i_a, i_b  : WIDTH-bit two's complement operands
//   i_fn      : function code (ADD, SUB, AND, XOR; anything else illegal)
//   o_result  : wrap-around result (0 for illegal fn)
//   o_ovf     : signed overflow (ADD/SUB only)
//   o_err     : illegal function code
//   o_cf      : carry (ADD) / borrow (SUB), only with ALU_PIPE_CARRY_FLAG_EN
// ---------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int FN_W  = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [FN_W-1:0]  i_fn,
    output logic [WIDTH-1:0] o_result,
    output logic             o_ovf,
`ifdef ALU_PIPE_CARRY_FLAG_EN
    output logic             o_cf,
`endif
    output logic             o_err
);
    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;

`ifdef ALU_PIPE_CARRY_FLAG_EN
    // One extra bit on the adder exposes the carry-out of bit WIDTH-1.
    logic [WIDTH:0] w_sum_x;
    assign w_sum_x = {1'b0, i_a} + {1'b0, i_b};
    assign w_sum   = w_sum_x[WIDTH-1:0];
`else
    assign w_sum   = i_a + i_b;
`endif
    assign w_diff  = i_a - i_b;

    always_comb begin
        o_result = '0;
        o_ovf    = 1'b0;
        o_err    = 1'b0;
`ifdef ALU_PIPE_CARRY_FLAG_EN
        o_cf     = 1'b0;
`endif
        case (i_fn)
            FN_W'(FN_ADD): begin
                o_result = w_sum;
                o_ovf    = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB] != i_a[MSB]);
`ifdef ALU_PIPE_CARRY_FLAG_EN
                o_cf     = w_sum_x[WIDTH];
`endif
            end
            FN_W'(FN_SUB): begin
                o_result = w_diff;
                o_ovf    = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);
`ifdef ALU_PIPE_CARRY_FLAG_EN
                o_cf     = (i_a < i_b);
`endif
            end
            FN_W'(FN_AND): o_result = i_a & i_b;
            FN_W'(FN_XOR): o_result = i_a ^ i_b;
            default:       o_err    = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_pipe_cc.sv
// ---------------------------------------------------------------------------
// alu_pipe_cc
// Two-stage pipelined Y86-64 OPq ALU holding the architectural CC register.
//   clk     : rising-edge clock
//   rst_n   : synchronous active-low reset
//   io_alu  : alu_pipe_cc_if.slave (operand/result handshakes, CC outputs)
// S1 registers operands on input handshake; S2 registers the alu_core
// outputs plus derived zf/sf. CC commits on the output handshake of a
// set_cc beat without err. Optional macro ALU_PIPE_CARRY_FLAG_EN adds cf.
// ---------------------------------------------------------------------------
module alu_pipe_cc
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int FN_W  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_pipe_cc_if.slave io_alu
);
    logic             r_s1_vld;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [FN_W-1:0]  r_s1_fn;
    logic             r_s1_set_cc;

    logic             r_s2_vld;
    logic [WIDTH-1:0] r_s2_result;
    logic             r_s2_ovf;
    logic             r_s2_err;
    logic             r_s2_set_cc;
    logic             r_s2_zf;
    logic             r_s2_sf;

    cc_t              r_cc;

    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic             w_err;
    logic             w_s1_adv;
    logic             w_s2_adv;
    logic             w_commit;

`ifdef ALU_PIPE_CARRY_FLAG_EN
    logic             w_cf;
    logic             r_s2_cf;
`endif

    alu_core #(.WIDTH(WIDTH), .FN_W(FN_W)) u_core (
        .i_a      (r_s1_a),
        .i_b      (r_s1_b),
        .i_fn     (r_s1_fn),
        .o_result (w_res),
        .o_ovf    (w_ovf),
`ifdef ALU_PIPE_CARRY_FLAG_EN
        .o_cf     (w_cf),
`endif
        .o_err    (w_err)
    );

    // Ready chains backwards from state only, never from in_valid.
    assign w_s2_adv = !r_s2_vld || io_alu.out_ready;
    assign w_s1_adv = !r_s1_vld || w_s2_adv;
    assign w_commit = r_s2_vld && io_alu.out_ready && r_s2_set_cc && !r_s2_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_vld    <= 1'b0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_fn     <= '0;
            r_s1_set_cc <= 1'b0;
            r_s2_vld    <= 1'b0;
            r_s2_result <= '0;
            r_s2_ovf    <= 1'b0;
            r_s2_err    <= 1'b0;
            r_s2_set_cc <= 1'b0;
            r_s2_zf     <= 1'b0;
            r_s2_sf     <= 1'b0;
`ifdef ALU_PIPE_CARRY_FLAG_EN
            r_s2_cf     <= 1'b0;
`endif
            r_cc        <= CC_RESET;
        end else begin
            if (w_s1_adv) begin
                r_s1_vld <= io_alu.in_valid;
                if (io_alu.in_valid) begin
                    r_s1_a      <= io_alu.in_a;
                    r_s1_b      <= io_alu.in_b;
                    r_s1_fn     <= io_alu.in_fn;
                    r_s1_set_cc <= io_alu.in_set_cc;
                end
            end
            // Data only loads with a valid beat, so an emptied S2 keeps its
            // last result on the outputs.
            if (w_s2_adv) begin
                r_s2_vld <= r_s1_vld;
                if (r_s1_vld) begin
                    r_s2_result <= w_res;
                    r_s2_ovf    <= w_ovf;
                    r_s2_err    <= w_err;
                    r_s2_set_cc <= r_s1_set_cc;
                    r_s2_zf     <= (w_res == '0);
                    r_s2_sf     <= w_res[WIDTH-1];
`ifdef ALU_PIPE_CARRY_FLAG_EN
                    r_s2_cf     <= w_cf;
`endif
                end
            end
            if (w_commit) begin
                r_cc.zf <= r_s2_zf;
                r_cc.sf <= r_s2_sf;
                r_cc.of <= r_s2_ovf;
`ifdef ALU_PIPE_CARRY_FLAG_EN
                r_cc.cf <= r_s2_cf;
`endif
            end
        end
    end

    assign io_alu.in_ready   = w_s1_adv;
    assign io_alu.out_valid  = r_s2_vld;
    assign io_alu.out_result = r_s2_result;
    assign io_alu.out_ovf    = r_s2_ovf;
    assign io_alu.out_err    = r_s2_err;
    assign io_alu.cc_zf      = r_cc.zf;
    assign io_alu.cc_sf      = r_cc.sf;
    assign io_alu.cc_of      = r_cc.of;
`ifdef ALU_PIPE_CARRY_FLAG_EN
    assign io_alu.out_cf     = r_s2_cf;
    assign io_alu.cc_cf      = r_cc.cf;
`endif

endmodule

// File: tb/tb_alu_pipe_cc.sv
// ---------------------------------------------------------------------------
// tb_alu_pipe_cc
// Bench for alu_pipe_cc (WIDTH=64). A queue of expected results is built
// from plain wide-integer arithmetic at each input handshake; the CC model
// updates on output handshakes. Optional macro ALU_PIPE_CARRY_FLAG_EN
// enables the carry-flag checks.
// ---------------------------------------------------------------------------
module tb_alu_pipe_cc;
    localparam int W = 64;

    typedef struct {
        logic [63:0] r;
        logic        ovf;
        logic        err;
        logic        scc;
        logic        cf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;
    int   n_out;
    exp_t q[$];
    logic [3:0] mcc;   // {zf, sf, of, cf}; cf bit unused without carry flag

    alu_pipe_cc_if #(.WIDTH(W), .FN_W(4)) bus ();

    alu_pipe_cc #(.WIDTH(W), .FN_W(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_alu (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [3:0] cc_now();
`ifdef ALU_PIPE_CARRY_FLAG_EN
        return {bus.cc_zf, bus.cc_sf, bus.cc_of, bus.cc_cf};
`else
        return {bus.cc_zf, bus.cc_sf, bus.cc_of, 1'b0};
`endif
    endfunction

    function automatic exp_t ref_op(logic [63:0] a, logic [63:0] b, logic [3:0] fn, logic scc);
        exp_t e;
        logic signed [65:0] sa, sb, full, rx;
        logic [64:0] ua;
        e.r = '0; e.ovf = 1'b0; e.err = 1'b0; e.cf = 1'b0; e.scc = scc;
        sa = {{2{a[63]}}, a};
        sb = {{2{b[63]}}, b};
        full = '0;
        case (fn)
            4'd0: begin
                full = sa + sb;
                e.r  = full[63:0];
                ua   = {1'b0, a} + {1'b0, b};
                e.cf = ua[64];
            end
            4'd1: begin
                full = sa - sb;
                e.r  = full[63:0];
                e.cf = (a < b);
            end
            4'd2: e.r = a & b;
            4'd3: e.r = a ^ b;
            default: e.err = 1'b1;
        endcase
        if (fn < 4'd2) begin
            // Overflow: true signed result does not fit in 64 bits.
            rx = {{2{e.r[63]}}, e.r};
            e.ovf = (full != rx);
        end
        return e;
    endfunction

    // Drive one cycle at the negedge, check outputs, update the model, then
    // advance to the next negedge.
    task automatic tick(input logic vld, input logic [63:0] a, input logic [63:0] b,
                        input logic [3:0] fn, input logic scc, input logic ordy,
                        output logic acc);
        exp_t e;
        bus.in_valid  = vld;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_fn     = fn;
        bus.in_set_cc = scc;
        bus.out_ready = ordy;
        #1;
        chk("in_ready", 64'(bus.in_ready), 64'((q.size() == 2 && !ordy) ? 1'b0 : 1'b1));
        chk("cc", 64'(cc_now()), 64'(mcc));
        if (bus.out_valid) begin
            chk("out_valid_has_beat", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
                e = q[0];
                chk("out_result", bus.out_result, e.r);
                chk("out_ovf", 64'(bus.out_ovf), 64'(e.ovf));
                chk("out_err", 64'(bus.out_err), 64'(e.err));
`ifdef ALU_PIPE_CARRY_FLAG_EN
                chk("out_cf", 64'(bus.out_cf), 64'(e.cf));
`endif
                if (ordy) begin
                    void'(q.pop_front());
                    n_out++;
                    if (e.scc && !e.err) begin
`ifdef ALU_PIPE_CARRY_FLAG_EN
                        mcc = {e.r == 64'd0, e.r[63], e.ovf, e.cf};
`else
                        mcc = {e.r == 64'd0, e.r[63], e.ovf, 1'b0};
`endif
                    end
                end
            end
        end
        acc = vld && bus.in_ready;
        if (acc) q.push_back(ref_op(a, b, fn, scc));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        logic acc;
        tick(1'b0, 64'd0, 64'd0, 4'd0, 1'b0, ordy, acc);
    endtask

    // Single beat, unstalled: checks the two-cycle latency and leaves the
    // bench at the negedge where the result is on the outputs.
    task automatic send1(input logic [63:0] a, input logic [63:0] b, input logic [3:0] fn,
                         input logic scc);
        logic acc;
        tick(1'b1, a, b, fn, scc, 1'b1, acc);
        chk("send_acc", 64'(acc), 64'd1);
        chk("lat1_out_valid", 64'(bus.out_valid), 64'd0);
        idle(1'b1);
        chk("lat2_out_valid", 64'(bus.out_valid), 64'd1);
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        mcc = 4'b1000;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) idle(1'b1);
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        logic acc;
        logic saw_stall;
        int   sent;
        logic [63:0] ra, rb;
        logic [3:0]  rfn;
        logic        rscc, pend;

        n_chk = 0; n_pass = 0; n_out = 0;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_fn = '0;
        bus.in_set_cc = 1'b0; bus.out_ready = 1'b0;
        mcc = 4'b1000;
        rst_n = 1'b0;
        @(negedge clk);
        do_reset();

        // Reset state
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_cc", 64'(cc_now()), 64'h8);
        chk("rst_out_result", bus.out_result, 64'd0);

        // ADD 5+7 with set_cc
        send1(64'd5, 64'd7, 4'd0, 1'b1);
        chk("add_result", bus.out_result, 64'd12);
        idle(1'b1);
        chk("add_cc", 64'(cc_now()), 64'h0);

        // Signed overflow on ADD
        send1(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'd0, 1'b1);
        chk("ovf_result", bus.out_result, 64'h8000_0000_0000_0000);
        chk("ovf_flag", 64'(bus.out_ovf), 64'd1);
        idle(1'b1);
        chk("ovf_cc", 64'(cc_now() & 4'b1110), 64'h6);

        // SUB 3-3, set_cc=0 then set_cc=1
        send1(64'd3, 64'd3, 4'd1, 1'b0);
        chk("sub0_result", bus.out_result, 64'd0);
        idle(1'b1);
        chk("sub0_cc_held", 64'(cc_now() & 4'b1110), 64'h6);
        send1(64'd3, 64'd3, 4'd1, 1'b1);
        idle(1'b1);
        chk("sub1_cc", 64'(cc_now()), 64'h8);

        // Stream of 8 beats, out_ready low on cycles 3..6
        sent = 0; saw_stall = 1'b0; n_out = 0;
        for (int c = 0; c < 40 && (sent < 8 || q.size() != 0); c++) begin
            if (!bus.in_ready) saw_stall = 1'b1;
            tick(sent < 8, 64'(sent * 100 + 1), 64'(sent), 4'(sent % 4), 1'b0,
                 !(c >= 3 && c <= 6), acc);
            if (acc) sent++;
        end
        chk("stream_sent", 64'(sent), 64'd8);
        chk("stream_out", 64'(n_out), 64'd8);
        chk("stream_in_ready_dropped", 64'(saw_stall), 64'd1);
        drain();

        // Illegal function code
        send1(64'd9, 64'd4, 4'd7, 1'b1);
        chk("ill_err", 64'(bus.out_err), 64'd1);
        chk("ill_result", bus.out_result, 64'd0);
        idle(1'b1);
        chk("ill_cc_held", 64'(cc_now()), 64'h8);

        // Commit something non-reset, then reset with two beats in flight
        send1(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 4'd3, 1'b1);
        idle(1'b1);
        tick(1'b1, 64'd1, 64'd1, 4'd0, 1'b1, 1'b0, acc);
        tick(1'b1, 64'd2, 64'd2, 4'd0, 1'b1, 1'b0, acc);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            chk("rst_flight_out_valid", 64'(bus.out_valid), 64'd0);
            idle(1'b1);
        end
        chk("rst_flight_cc", 64'(cc_now()), 64'h8);

`ifdef ALU_PIPE_CARRY_FLAG_EN
        send1(64'd1, 64'd2, 4'd1, 1'b1);
        chk("cf_sub_result", bus.out_result, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("cf_sub_cf", 64'(bus.out_cf), 64'd1);
        chk("cf_sub_ovf", 64'(bus.out_ovf), 64'd0);
        idle(1'b1);
        send1(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd0, 1'b1);
        chk("cf_add_result", bus.out_result, 64'd0);
        chk("cf_add_cf", 64'(bus.out_cf), 64'd1);
        idle(1'b1);
        chk("cf_add_cc", 64'(cc_now()), 64'h9);
`endif

        // Randomized traffic against the model
        pend = 1'b0; ra = '0; rb = '0; rfn = '0; rscc = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                pend = 1'b1;
                case ($urandom_range(0, 5))
                    0: ra = 64'h7FFF_FFFF_FFFF_FFFF;
                    1: ra = 64'h8000_0000_0000_0000;
                    2: ra = 64'hFFFF_FFFF_FFFF_FFFF;
                    default: ra = {$urandom, $urandom};
                endcase
                case ($urandom_range(0, 5))
                    0: rb = 64'd1;
                    1: rb = ra;
                    2: rb = 64'h8000_0000_0000_0000;
                    default: rb = {$urandom, $urandom};
                endcase
                rfn  = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 3))
                                                   : 4'($urandom_range(4, 15));
                rscc = 1'($urandom_range(0, 1));
            end
            tick(pend, ra, rb, rfn, rscc, $urandom_range(0, 3) != 0, acc);
            if (acc) pend = 1'b0;
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
